controlador_lavagem: RTL and testbench

CONTROLADOR_LAVAGEM -- requirements
Module: controlador_lavagem

---
 rtl/controlador_lavagem_if.sv | 29 ++
 rtl/controlador_lavagem.sv | 155 +++++++++++++++
 tb/tb_controlador_lavagem.sv | 136 +++++++++++++
 3 files changed

// File: rtl/controlador_lavagem_if.sv
// Signal bundle between the washing-machine controller and its plant:
// start/lid/level sensors in, actuator commands and status out.
interface controlador_lavagem_if;
    logic       iniciar;
    logic       tampa_aberta;
    logic       nivel_cheio;
    logic       nivel_vazio;
    logic       valvula_entrada;
    logic       bomba_saida;
    logic       lavar;
    logic       centrifugar_en;
    logic [3:0] fase;
    logic       concluido;
    logic       erro;

    // Plant / operator side: drives sensors and start, observes actuators.
    modport master (
        output iniciar, tampa_aberta, nivel_cheio, nivel_vazio,
        input  valvula_entrada, bomba_saida, lavar, centrifugar_en,
        input  fase, concluido, erro
    );

    // Controller side.
    modport slave (
        input  iniciar, tampa_aberta, nivel_cheio, nivel_vazio,
        output valvula_entrada, bomba_saida, lavar, centrifugar_en,
        output fase, concluido, erro
    );
endinterface

// File: rtl/controlador_lavagem.sv
// Washing-machine cycle controller: fill, wash, drain, fill, rinse, drain,
// spin, done. One shared 8-bit phase counter times the agitation/spin phases
// and the fill/drain timeouts. An open lid pauses the cycle in place.
module controlador_lavagem #(
    parameter int unsigned T_LAVAR      = 10,
    parameter int unsigned T_ENXAGUE    = 6,
    parameter int unsigned T_CENTRIF    = 5,
    parameter int unsigned T_MAX_ENCHER = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    controlador_lavagem_if.slave  bus
);

    typedef enum logic [3:0] {
        PARADO      = 4'd0,
        ENCHER1     = 4'd1,
        LAVAR       = 4'd2,
        DRENAR1     = 4'd3,
        ENCHER2     = 4'd4,
        ENXAGUAR    = 4'd5,
        DRENAR2     = 4'd6,
        CENTRIFUGAR = 4'd7,
        FIM         = 4'd8,
        ERRO        = 4'd9
    } estado_t;

    // Terminal counts: a phase of length T ends on the active cycle where
    // the counter reads T-1.
    localparam logic [7:0] LIM_LAVAR    = 8'(T_LAVAR - 1);
    localparam logic [7:0] LIM_ENXAGUE  = 8'(T_ENXAGUE - 1);
    localparam logic [7:0] LIM_CENTRIF  = 8'(T_CENTRIF - 1);
    localparam logic [7:0] LIM_ENCHER   = 8'(T_MAX_ENCHER - 1);

    estado_t    estado_q, estado_d;
    logic [7:0] cont_q, cont_d;
    logic       pausado_q, pausado_d;
    logic       em_ciclo;
    logic       ativo;

    // State, counter and pause flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= PARADO;
            cont_q    <= 8'd0;
            pausado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            pausado_q <= pausado_d;
        end
    end

    // Next-state, counter and output decode; outputs depend only on
    // registered state and the pause flag.
    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        pausado_d  = 1'b0;

        bus.valvula_entrada = 1'b0;
        bus.bomba_saida     = 1'b0;
        bus.lavar           = 1'b0;
        bus.centrifugar_en  = 1'b0;
        bus.concluido       = 1'b0;
        bus.erro            = 1'b0;
        bus.fase            = estado_q;

        em_ciclo = (estado_q >= ENCHER1) && (estado_q <= CENTRIFUGAR);
        ativo    = em_ciclo && !pausado_q;
        if (em_ciclo) begin
            pausado_d = bus.tampa_aberta;
        end

        case (estado_q)
            PARADO: begin
                if (bus.iniciar && !bus.tampa_aberta) begin
                    estado_d = ENCHER1;
                end
            end
            ENCHER1, ENCHER2: begin
                bus.valvula_entrada = !pausado_q;
                if (ativo) begin
                    // Sensor wins over a coincident timeout.
                    if (bus.nivel_cheio) begin
                        estado_d = (estado_q == ENCHER1) ? LAVAR : ENXAGUAR;
                    end else if (cont_q == LIM_ENCHER) begin
                        estado_d = ERRO;
                    end else begin
                        cont_d = cont_q + 8'd1;
                    end
                end
            end
            DRENAR1, DRENAR2: begin
                bus.bomba_saida = !pausado_q;
                if (ativo) begin
                    if (bus.nivel_vazio) begin
                        estado_d = (estado_q == DRENAR1) ? ENCHER2 : CENTRIFUGAR;
                    end else if (cont_q == LIM_ENCHER) begin
                        estado_d = ERRO;
                    end else begin
                        cont_d = cont_q + 8'd1;
                    end
                end
            end
            LAVAR: begin
                bus.lavar = !pausado_q;
                if (ativo) begin
                    if (cont_q == LIM_LAVAR) begin
                        estado_d = DRENAR1;
                    end else begin
                        cont_d = cont_q + 8'd1;
                    end
                end
            end
            ENXAGUAR: begin
                bus.lavar = !pausado_q;
                if (ativo) begin
                    if (cont_q == LIM_ENXAGUE) begin
                        estado_d = DRENAR2;
                    end else begin
                        cont_d = cont_q + 8'd1;
                    end
                end
            end
            CENTRIFUGAR: begin
                bus.centrifugar_en = !pausado_q;
                if (ativo) begin
                    if (cont_q == LIM_CENTRIF) begin
                        estado_d = FIM;
                    end else begin
                        cont_d = cont_q + 8'd1;
                    end
                end
            end
            FIM: begin
                bus.concluido = 1'b1;
                estado_d      = PARADO;
            end
            ERRO: begin
                // Only reset leaves the fault state.
                bus.erro = 1'b1;
            end
            default: begin
                estado_d = PARADO;
            end
        endcase

        // Every phase starts counting from zero.
        if (estado_d != estado_q) begin
            cont_d = 8'd0;
        end
    end

endmodule

// File: tb/tb_controlador_lavagem.sv
// Directed bench for controlador_lavagem. Each scenario is a pair of
// strings: expected fase per cycle (digit = state, letter a..g = state 1..7
// paused) and the stimulus applied in that cycle.
module tb_controlador_lavagem;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    controlador_lavagem_if bus ();

    controlador_lavagem #(
        .T_LAVAR      (4),
        .T_ENXAGUE    (3),
        .T_CENTRIF    (5),
        .T_MAX_ENCHER (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected actuator/status vector {valve, pump, lavar, spin, done, erro}.
    function automatic logic [7:0] outs_esperadas(input int f, input bit p);
        logic [7:0] v;
        v = 8'd0;
        v[5] = (f == 1 || f == 4) && !p;
        v[4] = (f == 3 || f == 6) && !p;
        v[3] = (f == 2 || f == 5) && !p;
        v[2] = (f == 7) && !p;
        v[1] = (f == 8);
        v[0] = (f == 9);
        return v;
    endfunction

    task automatic run_seq(input string tag, input string esp, input string stim);
        byte        c;
        int         f;
        bit         p;
        logic [7:0] obs;
        for (int i = 0; i < esp.len(); i++) begin
            c = esp[i];
            if (c >= 8'd48 && c <= 8'd57) begin
                f = int'(c) - 48;
                p = 1'b0;
            end else begin
                f = int'(c) - 96;
                p = 1'b1;
            end
            obs = {2'b00, bus.valvula_entrada, bus.bomba_saida, bus.lavar,
                   bus.centrifugar_en, bus.concluido, bus.erro};
            chk($sformatf("%s[%0d].fase", tag, i), {4'd0, bus.fase}, 8'(f));
            chk($sformatf("%s[%0d].outs", tag, i), obs, outs_esperadas(f, p));

            bus.iniciar      = 1'b0;
            bus.tampa_aberta = 1'b0;
            bus.nivel_cheio  = 1'b0;
            bus.nivel_vazio  = 1'b0;
            rst              = 1'b0;
            c = stim[i];
            case (c)
                "i": bus.iniciar = 1'b1;
                "t": bus.tampa_aberta = 1'b1;
                "c": bus.nivel_cheio = 1'b1;
                "v": bus.nivel_vazio = 1'b1;
                "r": rst = 1'b1;
                "x": begin bus.iniciar = 1'b1; bus.tampa_aberta = 1'b1; end
                "j": begin bus.iniciar = 1'b1; rst = 1'b1; end
                "y": begin bus.tampa_aberta = 1'b1; bus.nivel_cheio = 1'b1; end
                default: ;
            endcase
            tick();
        end
        $display("scenario %s: %0d cycles, %0d mismatches so far", tag, esp.len(), n_err);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst              = 1'b1;
        bus.iniciar      = 1'b0;
        bus.tampa_aberta = 1'b0;
        bus.nivel_cheio  = 1'b0;
        bus.nivel_vazio  = 1'b0;
        tick();
        tick();
        chk("reset.fase", {4'd0, bus.fase}, 8'd0);
        chk("reset.outs", {2'b00, bus.valvula_entrada, bus.bomba_saida, bus.lavar,
                           bus.centrifugar_en, bus.concluido, bus.erro}, 8'd0);
        rst = 1'b0;
        tick();

        // Full cycle, each sensor 2 cycles after phase entry.
        run_seq("full", "011122223334445556667777780",
                        "i--c------v--c-----v-------");
        // Lid open after 2 wash cycles; iniciar during LAVAR ignored.
        run_seq("pause_wash", "011122bbb2230",
                              "i--c-ttt-i-r-");
        // Lid open in fill: sensor ignored while paused.
        run_seq("pause_fill", "01aa120",
                              "ity-cr-");
        // Fill timeout to ERRO, iniciar ignored, rst together with iniciar.
        run_seq("timeout", "0111111119990",
                           "i--------i-j-");
        // Start blocked by open lid.
        run_seq("blocked", "000",
                           "x--");
        // Reset in the 3rd spin cycle: no completion pulse.
        run_seq("rst_spin", "01112222333444555666777000",
                            "i--c------v--c-----v--r---");
        // Drain sensor coincides with drain timeout: sensor wins.
        run_seq("tie", "011122223334445556666666670",
                       "i--c------v--c----------vr-");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
